// File: rtl/cp0_irq_pkg.sv
// Shared types and constants for the CP0 interrupt sequencer.
package cp0_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } irq_state_e;

  localparam int IP_SW0     = 0;
  localparam int IP_SW1     = 1;
  localparam int IP_HW_BASE = 2;
  localparam int IP_TIMER   = 7;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Index of the highest set bit, 0 when the vector is empty.
  function automatic logic [2:0] highest_bit(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cp0_irq_controller_sync.sv
// Multi-flop synchronizer chain for asynchronous level inputs.
module irq_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  // Each stage takes the previous one; stage 0 samples the raw input.
  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Chain registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_irq_controller.sv
// CP0 interrupt sequencer: Cause.IP formation, Count/Compare timer and
// request/accept handshake with a holdoff against re-raising.
module cp0_irq_controller
  import cp0_irq_pkg::*;
#(
  parameter int N_HW        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MAX    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_HW-1:0] hwIrq,
  input  logic            swIrqWrite,
  input  logic [1:0]      swIrqData,
  input  logic            countWrite,
  input  logic            compareWrite,
  input  logic [31:0]     cp0WData,
  input  logic            statusIE,
  input  logic            statusEXL,
  input  logic            statusERL,
  input  logic [7:0]      statusIM,
  input  logic            excAccept,
  output logic            interrupt,
  output logic [7:0]      causeIP,
  output logic [31:0]     countOut,
  output logic [31:0]     compareOut,
  output logic [2:0]      irqIndex
);

  localparam int HOLD_CW = $clog2(HOLD_MAX + 1);

  logic [N_HW-1:0]    hw_sync;
  logic [4:0]         hw_ip;
  logic [1:0]         sw_q, sw_d;
  logic [31:0]        count_q, count_d, count_inc;
  logic [31:0]        compare_q, compare_d;
  logic               half_q, half_d;
  logic               timer_pend_q, timer_pend_d;
  irq_state_e         state_q, state_d;
  logic [HOLD_CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]         masked;
  logic               en;

  irq_sync #(.WIDTH(N_HW), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (hwIrq),
    .dout (hw_sync)
  );

  // Unused hardware line positions read as zero.
  always_comb begin
    hw_ip = '0;
    hw_ip[N_HW-1:0] = hw_sync;
  end

  assign causeIP  = {timer_pend_q, hw_ip, sw_q};
  assign masked   = causeIP & statusIM;
  assign en       = (|masked) & statusIE & ~statusEXL & ~statusERL;
  assign irqIndex = highest_bit(masked);

  assign count_inc = count_q + 32'd1;

  // Software bits and timer; register writes take priority over a match.
  always_comb begin
    sw_d         = sw_q;
    half_d       = ~half_q;
    count_d      = count_q;
    compare_d    = compare_q;
    timer_pend_d = timer_pend_q;
    if (swIrqWrite) sw_d = swIrqData;
    if (half_q) begin
      count_d = count_inc;
      if (count_inc == compare_q) timer_pend_d = 1'b1;
    end
    if (countWrite) begin
      count_d      = cp0WData;
      half_d       = 1'b0;
      timer_pend_d = timer_pend_q;
    end
    if (compareWrite) begin
      compare_d    = cp0WData;
      timer_pend_d = 1'b0;
    end
  end

  // Handshake FSM: accept of any exception moves to HOLD until EXL/ERL is
  // seen (or the holdoff expires), so the same line is not taken twice.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_REQ;
      ST_REQ: begin
        if (excAccept) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end else if (!en) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (statusEXL || statusERL || hold_cnt_q == HOLD_CW'(HOLD_MAX - 1)) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q         <= '0;
      half_q       <= 1'b0;
      count_q      <= '0;
      compare_q    <= COMPARE_RST;
      timer_pend_q <= 1'b0;
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
    end else begin
      sw_q         <= sw_d;
      half_q       <= half_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      timer_pend_q <= timer_pend_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign interrupt  = (state_q == ST_REQ);
  assign countOut   = count_q;
  assign compareOut = compare_q;

endmodule

// File: tb/tb_cp0_irq_controller.sv
// Directed bench for cp0_irq_controller.
module tb_cp0_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hwIrq;
  logic        swIrqWrite;
  logic [1:0]  swIrqData;
  logic        countWrite;
  logic        compareWrite;
  logic [31:0] cp0WData;
  logic        statusIE, statusEXL, statusERL;
  logic [7:0]  statusIM;
  logic        excAccept;
  logic        interrupt;
  logic [7:0]  causeIP;
  logic [31:0] countOut, compareOut;
  logic [2:0]  irqIndex;

  int checks = 0;
  int errors = 0;

  cp0_irq_controller #(.N_HW(5), .SYNC_STAGES(2), .HOLD_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .hwIrq        (hwIrq),
    .swIrqWrite   (swIrqWrite),
    .swIrqData    (swIrqData),
    .countWrite   (countWrite),
    .compareWrite (compareWrite),
    .cp0WData     (cp0WData),
    .statusIE     (statusIE),
    .statusEXL    (statusEXL),
    .statusERL    (statusERL),
    .statusIM     (statusIM),
    .excAccept    (excAccept),
    .interrupt    (interrupt),
    .causeIP      (causeIP),
    .countOut     (countOut),
    .compareOut   (compareOut),
    .irqIndex     (irqIndex)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hwIrq = '0; swIrqWrite = 0; swIrqData = '0;
    countWrite = 0; compareWrite = 0; cp0WData = '0;
    statusIE = 0; statusEXL = 0; statusERL = 0; statusIM = '0; excAccept = 0;
    tick(); tick();
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_causeIP", 32'(causeIP), 32'd0);
    check("rst_irqIndex", 32'(irqIndex), 32'd0);
    check("rst_count", countOut, 32'd0);
    check("rst_compare", compareOut, 32'hFFFF_FFFF);
    rst = 1'b0;

    // Hardware line 0 through synchronizer and handshake
    statusIE = 1; statusIM = 8'h04;
    hwIrq = 5'b00001;
    tick();
    check("hw_sync_stage1", 32'(causeIP), 32'h00);
    tick();
    check("hw_causeIP", 32'(causeIP), 32'h04);
    check("hw_irqIndex", 32'(irqIndex), 32'd2);
    check("hw_int_not_yet", 32'(interrupt), 32'd0);
    tick();
    check("hw_int_raised", 32'(interrupt), 32'd1);
    tick();
    check("hw_int_held", 32'(interrupt), 32'd1);
    excAccept = 1;
    tick();
    excAccept = 0;
    check("accept_drops", 32'(interrupt), 32'd0);
    statusEXL = 1;
    tick();
    check("exl_idle", 32'(interrupt), 32'd0);
    tick();
    check("exl_no_reraise", 32'(interrupt), 32'd0);
    statusEXL = 0;
    check("exl_drop_latency", 32'(interrupt), 32'd0);
    tick();
    check("reraise", 32'(interrupt), 32'd1);

    // Withdrawal by masking
    statusIM = 8'h00;
    tick();
    check("withdraw", 32'(interrupt), 32'd0);
    check("withdraw_index", 32'(irqIndex), 32'd0);
    statusIM = 8'h04;
    tick();
    check("rerequest", 32'(interrupt), 32'd1);

    // HOLD timeout with EXL never raised
    excAccept = 1;
    tick();
    excAccept = 0;
    check("hold_enter", 32'(interrupt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_wait%0d", i), 32'(interrupt), 32'd0);
    end
    tick();
    check("hold_timeout_req", 32'(interrupt), 32'd1);

    // Drop line, mask to timer only
    hwIrq = '0; statusIE = 0; statusIM = 8'h80;
    tick(); tick();
    check("hw_cleared", 32'(causeIP), 32'h00);

    // Timer match: Compare = 12, Count = 10
    compareWrite = 1; cp0WData = 32'd12;
    tick();
    compareWrite = 0;
    check("compare_wr", compareOut, 32'd12);
    countWrite = 1; cp0WData = 32'd10;
    tick();
    countWrite = 0;
    check("count_wr", countOut, 32'd10);
    tick(); tick();
    check("count_inc", countOut, 32'd11);
    tick();
    check("timer_not_yet", 32'(causeIP), 32'h00);
    tick();
    check("timer_pend", 32'(causeIP), 32'h80);
    check("timer_index", 32'(irqIndex), 32'd7);
    compareWrite = 1; cp0WData = 32'd12;
    tick();
    compareWrite = 0;
    check("compare_clears", 32'(causeIP), 32'h00);

    // countWrite in the match cycle suppresses timerPend
    countWrite = 1; cp0WData = 32'd10;
    tick();
    countWrite = 0;
    tick(); tick(); tick();
    check("pre_match_count", countOut, 32'd11);
    countWrite = 1; cp0WData = 32'd100;
    tick();
    countWrite = 0;
    check("match_write_wins", 32'(causeIP), 32'h00);
    check("match_write_count", countOut, 32'd100);
    tick(); tick();
    check("match_write_still0", 32'(causeIP), 32'h00);

    // Count wrap
    countWrite = 1; cp0WData = 32'hFFFF_FFFF;
    tick();
    countWrite = 0;
    check("wrap_load", countOut, 32'hFFFF_FFFF);
    tick();
    check("wrap_hold", countOut, 32'hFFFF_FFFF);
    tick();
    check("wrap_zero", countOut, 32'd0);

    // Software bit into REQ, then asynchronous reset
    statusIE = 1; statusIM = 8'h01;
    swIrqWrite = 1; swIrqData = 2'b01;
    tick();
    swIrqWrite = 0;
    check("sw_causeIP", 32'(causeIP), 32'h01);
    check("sw_index", 32'(irqIndex), 32'd0);
    tick();
    check("sw_int", 32'(interrupt), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_interrupt", 32'(interrupt), 32'd0);
    check("arst_causeIP", 32'(causeIP), 32'd0);
    check("arst_count", countOut, 32'd0);
    check("arst_compare", compareOut, 32'hFFFF_FFFF);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_int", 32'(interrupt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_irq_controller.md
# cp0_irq_controller

Interrupt sequencer for coprocessor 0. Synchronizes external interrupt lines, maintains the Count/Compare timer and software interrupt bits, and forms the Cause.IP vector. It masks pending interrupts against Status and drives the single `interrupt` request into the exception controller. A request/accept handshake with an anti-re-raise holdoff ensures one interrupt is taken exactly once per exception entry.

## Interface
Parameters:
- `N_HW`, 5, number of hardware interrupt lines; maps to IP[2+N_HW-1:2]; legal values 1..5.
- `SYNC_STAGES`, 2, synchronizer flops per hardware line; legal values ≥2.
- `HOLD_MAX`, 4, maximum HOLD cycles before forced return to IDLE; legal values ≥2.

Ports (reset is asynchronous and active-high; one clock):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-high reset
- `hwIrq`  in  N_HW  asynchronous level-sensitive external interrupt lines
- `swIrqWrite`  in  1  mtc0 to Cause this cycle
- `swIrqData`  in  2  new Cause.IP[1:0]
- `countWrite`  in  1  mtc0 to Count
- `compareWrite`  in  1  mtc0 to Compare
- `cp0WData`  in  32  write data for Count/Compare
- `statusIE`, `statusEXL`, `statusERL`  in  1 each  Status bits
- `statusIM`  in  8  Status.IM
- `excAccept`  in  1  exception controller accepted any exception this cycle
- `interrupt`  out  1  masked interrupt request to exception controller
- `causeIP`  out  8  Cause.IP read value
- `countOut`, `compareOut`  out  32 each  register read values
- `irqIndex`  out  3  highest-numbered enabled pending IP bit (0 when none)

## Operation
- **Synchronizer:** `hwIrq` is sampled through `SYNC_STAGES` flops per line. The final stage drives `causeIP[2+i]`.
- **Software bits:** `causeIP[1:0]` is a register loaded from `swIrqData` on `swIrqWrite`.
- **Timer:** `count` increments by 1 every second cycle, driven by a toggle bit `half`. It wraps 0xFFFFFFFF→0.
  - `countWrite` loads `cp0WData` and clears `half`.
  - `compareWrite` loads Compare and clears `timerPend`.
  - `timerPend` sets in the cycle `count` increments to a value equal to Compare. `causeIP[7]` = `timerPend`.
- **Enabled request:** `en` = `|(causeIP & statusIM) & statusIE & ~statusEXL & ~statusERL`.
- **`irqIndex`:** highest set bit of `causeIP & statusIM`, regardless of IE/EXL.
- **FSM** (states IDLE, REQ, HOLD):
  - IDLE → REQ when `en`.
  - REQ → HOLD on `excAccept`. This applies to any exception, since EXL will rise either way.
  - REQ → IDLE when `~en` and `~excAccept`. The request is withdrawn and no exception is taken.
  - HOLD → IDLE when `statusEXL | statusERL` is observed high, or after `HOLD_MAX` cycles in HOLD.
  - `interrupt` = (state == REQ), registered.
- **Simultaneous events:**
  - `countWrite` together with a match: the write wins and `timerPend` is not set.
  - `compareWrite` together with a match: the clear wins.
  - `swIrqWrite` does not affect IP[7:2].
  - `excAccept` in IDLE or HOLD is ignored.

## Timing
- **Reset values:**
  - `count` = 0, Compare = 0xFFFFFFFF, `half` = 0.
  - `timerPend` = 0, software bits = 0, synchronizer flops = 0.
  - State = IDLE, `interrupt` = 0, `causeIP` = 0, `irqIndex` = 0.
- **Reset mid-operation:** asynchronous reset returns all of the above immediately, including from REQ or HOLD.
- **Latencies:**
  - `hwIrq` edge → `causeIP` change: `SYNC_STAGES` cycles.
  - `causeIP` / Status change → `interrupt` change: 1 cycle.
  - `excAccept` in cycle t → `interrupt` low in cycle t+1. It is never high in t+1 even if `en` is still high, because EXL is not yet visible.
- **Register writes:**
  - Count/Compare writes are visible on `countOut`/`compareOut` the next cycle.
  - `timerPend` updates the cycle after the matching increment.
- **Handshake:** `interrupt` holds high until it is accepted or withdrawn. There is no combinational path from `excAccept` to `interrupt`.

## Structure
- **Shared package `cp0_irq_pkg`:**
  - FSM state typedef (IDLE, REQ, HOLD).
  - IP bit-position constants: IP_SW0 = 0, IP_SW1 = 1, IP_HW_BASE = 2, IP_TIMER = 7.
  - Compare reset constant 32'hFFFFFFFF.
- **Sub-module `irq_sync`:** parameterized width × `SYNC_STAGES` flop chain with asynchronous reset, instantiated once for `hwIrq`.

## Test plan
- **Hardware path:** IE=1, IM=0x04, EXL=0; pulse `hwIrq[0]` high → `causeIP` = 0x04 after 2 cycles, `interrupt` = 1 one cycle later, `irqIndex` = 2. `excAccept` for 1 cycle → `interrupt` = 0 next cycle. Raise EXL → state IDLE, no re-raise. Drop EXL with the line still high → `interrupt` re-asserts 1 cycle later.
- **Timer match:** write Count = 10, Compare = 12, IM[7] = 1 → `timerPend` sets 4–5 cycles after the write, `causeIP[7]` = 1. Write Compare → `causeIP[7]` = 0 next cycle.
- **Simultaneous events:** `countWrite` in the match cycle → no `timerPend`. Count = 0xFFFFFFFF → wraps to 0 after 2 cycles.
- **Withdrawal:** in REQ, clear `statusIM` → `interrupt` falls next cycle, state IDLE, with no `excAccept`.
- **HOLD timeout:** `excAccept` while in REQ with EXL never raised → return to IDLE after `HOLD_MAX` (4) cycles, then re-request.
- **Reset:** assert `rst` asynchronously while in REQ → `interrupt`, `causeIP`, and `countOut` go to 0 immediately, and Compare reads 0xFFFFFFFF.
